// File: rtl/image_stream_source_if.sv
// Write port and pixel stream of image_stream_source, seen from the DUT (slave)
// and from whatever loads the image and consumes the stream (master).
interface image_stream_source_if #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned ROW_SIZE  = 28,
  parameter int unsigned COL_SIZE  = 28
);
  localparam int unsigned ADDR_W = (ROW_SIZE * COL_SIZE > 1) ? $clog2(ROW_SIZE * COL_SIZE) : 1;

  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [DATA_SIZE-1:0] wr_data;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [DATA_SIZE-1:0] pixel_out;
  logic                 pixel_valid;
  logic                 pixel_last;
  logic                 win_inside;

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    output busy, done, pixel_out, pixel_valid, pixel_last, win_inside
  );

  modport master (
    output wr_en, wr_addr, wr_data, start,
    input  busy, done, pixel_out, pixel_valid, pixel_last, win_inside
  );
endinterface

// File: rtl/image_stream_source.sv
// Image RAM replayed in raster order as one gap-free valid-qualified pixel stream,
// with a per-pixel flag telling whether a KxK window ending there lies inside the image.
module image_stream_source #(
  parameter int unsigned DATA_SIZE   = 8,
  parameter int unsigned ROW_SIZE    = 28,
  parameter int unsigned COL_SIZE    = 28,
  parameter int unsigned KERNEL_SIZE = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  image_stream_source_if.slave bus
);
  localparam int unsigned NPIX = ROW_SIZE * COL_SIZE;
  localparam int unsigned AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned RW   = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam int unsigned CW   = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [RW-1:0]        row_q, row_d;
  logic [CW-1:0]        col_q, col_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rd_en;
  logic                 rd_vld_q, rd_win_q, rd_last_q;
  logic                 rd_win_d, rd_last_d;
  logic                 s_vld_q, s_win_q, s_last_q;
  logic [DATA_SIZE-1:0] s_data_q;
  logic [DATA_SIZE-1:0] pixel_out_q, pixel_out_d;
  logic                 pixel_valid_q, pixel_last_q, win_inside_q;

  logic [DATA_SIZE-1:0] mem [NPIX];
  logic [DATA_SIZE-1:0] ram_rd_q;

  // Sequencer: the read address is issued on the same edge it is computed,
  // so the start edge reads pixel 0 before any write on that edge lands.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    row_d   = row_q;
    col_d   = col_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = STREAM;
          busy_d  = 1'b1;
          addr_d  = '0;
          row_d   = '0;
          col_d   = '0;
          rd_en   = 1'b1;
        end
      end
      STREAM: begin
        if (addr_q == AW'(NPIX - 1)) begin
          state_d = DRAIN;
        end else begin
          rd_en  = 1'b1;
          addr_d = addr_q + AW'(1);
          if (col_q == CW'(ROW_SIZE - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (pixel_last_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    rd_win_d    = (row_d >= RW'(KERNEL_SIZE - 1)) && (col_d >= CW'(KERNEL_SIZE - 1));
    rd_last_d   = (addr_d == AW'(NPIX - 1));
    pixel_out_d = s_vld_q ? s_data_q : '0;
  end

  // Control, sideband pipeline and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      row_q         <= '0;
      col_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_vld_q      <= 1'b0;
      rd_win_q      <= 1'b0;
      rd_last_q     <= 1'b0;
      s_vld_q       <= 1'b0;
      s_win_q       <= 1'b0;
      s_last_q      <= 1'b0;
      s_data_q      <= '0;
      pixel_out_q   <= '0;
      pixel_valid_q <= 1'b0;
      pixel_last_q  <= 1'b0;
      win_inside_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      row_q         <= row_d;
      col_q         <= col_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rd_vld_q      <= rd_en;
      rd_win_q      <= rd_en & rd_win_d;
      rd_last_q     <= rd_en & rd_last_d;
      s_vld_q       <= rd_vld_q;
      s_win_q       <= rd_win_q;
      s_last_q      <= rd_last_q;
      s_data_q      <= ram_rd_q;
      pixel_out_q   <= pixel_out_d;
      pixel_valid_q <= s_vld_q;
      pixel_last_q  <= s_vld_q & s_last_q;
      win_inside_q  <= s_vld_q & s_win_q;
    end
  end

  // Image RAM: contents survive reset; writes only while idle and in range.
  always_ff @(posedge clock) begin
    if (bus.wr_en && !busy_q && (32'(bus.wr_addr) < NPIX)) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
    if (rd_en) begin
      ram_rd_q <= mem[addr_d];
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pixel_out   = pixel_out_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.pixel_last  = pixel_last_q;
  assign bus.win_inside  = win_inside_q;
endmodule

// File: tb/tb_image_stream_source.sv
// Bench: 4x4 instance checked every cycle against a schedule-level model, 28x28 instance
// checked pixel by pixel against its raster formula, plus literal spot values.
module tb_image_stream_source;
  localparam int unsigned DW  = 8;
  localparam int unsigned RA  = 4, CA = 4, KA = 3, NA = RA * CA, AWA = 4;
  localparam int unsigned RB  = 28, CB = 28, KB = 3, NB = RB * CB, AWB = 10;

  logic clock = 1'b0;
  logic rst_a, rst_b;
  always #5 clock = ~clock;

  image_stream_source_if #(.DATA_SIZE(DW), .ROW_SIZE(RA), .COL_SIZE(CA)) bus_a ();
  image_stream_source_if #(.DATA_SIZE(DW), .ROW_SIZE(RB), .COL_SIZE(CB)) bus_b ();

  image_stream_source #(.DATA_SIZE(DW), .ROW_SIZE(RA), .COL_SIZE(CA), .KERNEL_SIZE(KA))
    dut_a (.clock(clock), .reset_n(rst_a), .bus(bus_a));
  image_stream_source #(.DATA_SIZE(DW), .ROW_SIZE(RB), .COL_SIZE(CB), .KERNEL_SIZE(KB))
    dut_b (.clock(clock), .reset_n(rst_b), .bus(bus_b));

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- model of the 4x4 instance ----------------
  // k counts edges since the accepting start edge: busy for k=0..NA+1,
  // pixel k-2 shown for k=2..NA+1, done right after edge NA+2.
  logic [DW-1:0] img  [NA];
  logic [DW-1:0] snap [NA];
  bit m_idle = 1'b1;
  bit m_done = 1'b0;
  int m_k    = 0;

  always @(posedge clock or negedge rst_a) begin
    if (!rst_a) begin
      m_idle = 1'b1;
      m_done = 1'b0;
      m_k    = 0;
    end else begin
      bit was_idle;
      was_idle = m_idle;
      m_done   = 1'b0;
      if (m_idle) begin
        if (bus_a.start) begin
          snap   = img;
          m_idle = 1'b0;
          m_k    = 0;
        end
      end else begin
        m_k++;
        if (m_k == NA + 2) begin
          m_idle = 1'b1;
          m_done = 1'b1;
        end
      end
      if (was_idle && bus_a.wr_en && (32'(bus_a.wr_addr) < NA)) img[bus_a.wr_addr] = bus_a.wr_data;
    end
  end

  int valid_a = 0, win_a = 0, done_a = 0, rise_a = 0;
  bit prev_a = 1'b0;

  always @(negedge clock) begin
    logic [DW+4:0] e, a;
    int p;
    e = '0;
    p = m_k - 2;
    e[DW+4] = !m_idle;
    e[DW+3] = m_done;
    if (!m_idle && m_k >= 2 && m_k <= NA + 1) begin
      e[DW+2]   = 1'b1;
      e[DW+1]   = (p == NA - 1);
      e[DW]     = ((p / RA) >= KA - 1) && ((p % RA) >= KA - 1);
      e[DW-1:0] = snap[p];
    end
    a = {bus_a.busy, bus_a.done, bus_a.pixel_valid, bus_a.pixel_last, bus_a.win_inside, bus_a.pixel_out};
    check("a_cycle{busy,done,valid,last,win,pix}", 64'(a), 64'(e));
    if (bus_a.pixel_valid) valid_a++;
    if (bus_a.win_inside) win_a++;
    if (bus_a.done) done_a++;
    if (bus_a.pixel_valid && !prev_a) rise_a++;
    prev_a = bus_a.pixel_valid;
  end

  // ---------------- raster checker of the 28x28 instance ----------------
  int b_idx = 0, b_win = 0, b_first_win = -1, b_rise = 0, b_done = 0;
  logic [DW-1:0] b_first_pix = '1;
  bit b_prev = 1'b0;
  bit b_finished = 1'b0;

  always @(negedge clock) begin
    if (rst_b === 1'b1) begin
      if (bus_b.pixel_valid) begin
        logic [DW+1:0] e;
        e = {(b_idx / RB >= KB - 1) && (b_idx % RB >= KB - 1), (b_idx == NB - 1), DW'(b_idx % 256)};
        check("b_pixel{win,last,pix}", 64'({bus_b.win_inside, bus_b.pixel_last, bus_b.pixel_out}), 64'(e));
        if (b_idx == 0) b_first_pix = bus_b.pixel_out;
        if (bus_b.win_inside) begin
          if (b_win == 0) b_first_win = b_idx;
          b_win++;
        end
        b_idx++;
      end
      if (bus_b.pixel_valid && !b_prev) b_rise++;
      b_prev = bus_b.pixel_valid;
      if (bus_b.done) b_done++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr_a(input int addr, input int data);
    @(negedge clock);
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = AWA'(addr);
    bus_a.wr_data = DW'(data);
  endtask

  // Returns at the negedge right after the sampling edge E.
  task automatic start_a();
    @(negedge clock);
    bus_a.start = 1'b1;
    @(negedge clock);
    bus_a.start = 1'b0;
  endtask

  task automatic wait_done_a(input int limit);
    int n = 0;
    while (bus_a.done !== 1'b1 && n < limit) begin
      @(negedge clock);
      n++;
    end
    check("a_done_within_bound", 64'(bus_a.done), 64'(1));
  endtask

  int bv, bw, bd, br;

  initial begin
    rst_a = 1'b0;
    bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.start = 1'b0;
    repeat (3) @(negedge clock);
    rst_a = 1'b1;
    @(negedge clock);
    check("reset_busy",  64'(bus_a.busy), 64'(0));
    check("reset_valid", 64'(bus_a.pixel_valid), 64'(0));
    check("reset_pix",   64'(bus_a.pixel_out), 64'(0));
    check("reset_done",  64'(bus_a.done), 64'(0));

    for (int i = 0; i < NA; i++) wr_a(i, 8'h10 + i);
    @(negedge clock) bus_a.wr_en = 1'b0;

    // basic replay with latency, last, done and window count
    @(posedge clock); bv = valid_a; bw = win_a; bd = done_a;
    start_a();
    check("t1_busy_at_E", 64'(bus_a.busy), 64'(1));
    repeat (2) @(negedge clock);
    check("t1_first_pix", 64'({bus_a.pixel_valid, bus_a.pixel_out}), 64'({1'b1, 8'h10}));
    repeat (15) @(negedge clock);
    check("t1_last_pix", 64'({bus_a.pixel_valid, bus_a.pixel_last, bus_a.pixel_out}), 64'({2'b11, 8'h1F}));
    @(negedge clock);
    check("t1_done", 64'({bus_a.done, bus_a.busy, bus_a.pixel_valid}), 64'(3'b100));
    repeat (3) @(negedge clock);
    @(posedge clock);
    check("t1_valid_count", 64'(valid_a - bv), 64'(16));
    check("t2_win_count",   64'(win_a - bw), 64'(4));
    check("t1_done_count",  64'(done_a - bd), 64'(1));

    // start and write while busy are dropped
    start_a();
    repeat (4) @(negedge clock);
    bus_a.start = 1'b1;
    @(negedge clock);
    check("t3_pix3", 64'(bus_a.pixel_out), 64'(8'h13));
    bus_a.start = 1'b0;
    bus_a.wr_en = 1'b1; bus_a.wr_addr = AWA'(3); bus_a.wr_data = 8'hAA;
    @(negedge clock);
    bus_a.wr_en = 1'b0;
    wait_done_a(40);
    start_a();
    repeat (5) @(negedge clock);
    check("t3_pix3_kept", 64'(bus_a.pixel_out), 64'(8'h13));
    wait_done_a(40);

    // async reset mid-stream, then a full replay
    @(posedge clock); bd = done_a;
    start_a();
    repeat (9) @(negedge clock);
    check("t4_pix7", 64'(bus_a.pixel_out), 64'(8'h17));
    #2 rst_a = 1'b0;
    #1;
    check("t4_rst_outputs", 64'({bus_a.busy, bus_a.pixel_valid, bus_a.pixel_out}), 64'(0));
    repeat (2) @(negedge clock);
    rst_a = 1'b1;
    repeat (4) @(negedge clock);
    @(posedge clock);
    check("t4_no_done", 64'(done_a - bd), 64'(0));
    bv = valid_a;
    start_a();
    wait_done_a(40);
    @(posedge clock);
    check("t4_replay_count", 64'(valid_a - bv), 64'(16));

    // start held high: back-to-back images separated by idle cycles
    @(posedge clock); bv = valid_a; bd = done_a; br = rise_a;
    @(negedge clock) bus_a.start = 1'b1;
    repeat (41) @(negedge clock);
    bus_a.start = 1'b0;
    repeat (30) @(negedge clock);
    @(posedge clock);
    check("t5_done_count",  64'(done_a - bd), 64'(3));
    check("t5_valid_count", 64'(valid_a - bv), 64'(48));
    check("t5_valid_runs",  64'(rise_a - br), 64'(3));

    begin
      int n = 0;
      while (!b_finished && n < 3000) begin
        @(negedge clock);
        n++;
      end
      check("b_finished", 64'(b_finished), 64'(1));
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // 28x28 default image: pixel = addr mod 256
  initial begin
    rst_b = 1'b0;
    bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.start = 1'b0;
    repeat (3) @(negedge clock);
    rst_b = 1'b1;
    for (int i = 0; i < NB; i++) begin
      @(negedge clock);
      bus_b.wr_en = 1'b1; bus_b.wr_addr = AWB'(i); bus_b.wr_data = DW'(i % 256);
    end
    @(negedge clock) bus_b.wr_en = 1'b0;
    @(negedge clock) bus_b.start = 1'b1;
    @(negedge clock) bus_b.start = 1'b0;
    begin
      int n = 0;
      while (bus_b.done !== 1'b1 && n < NB + 50) begin
        @(negedge clock);
        n++;
      end
      check("b_done_within_bound", 64'(bus_b.done), 64'(1));
    end
    @(negedge clock);
    @(posedge clock);
    check("b_valid_count", 64'(b_idx), 64'(784));
    check("b_win_count",   64'(b_win), 64'(676));
    check("b_first_win",   64'(b_first_win), 64'(58));
    check("b_first_pix",   64'(b_first_pix), 64'(8'h00));
    check("b_valid_runs",  64'(b_rise), 64'(1));
    check("b_done_count",  64'(b_done), 64'(1));
    b_finished = 1'b1;
  end
endmodule

// File: doc/image_stream_source.md
Name: image_stream_source

Overview:
- Transmit end of the sliding-window pixel stream.
- Holds one single-channel image in an internal RAM, loaded through a write port.
- On a start pulse, replays the image in raster order as one contiguous valid-qualified pixel stream. This feeds the KxK window-generation buffer, whose fill counter clears whenever valid drops.
- Also flags, per pixel, whether a KxK window ending on that pixel lies fully inside the image, so the downstream window stream can be qualified.

Parameters:
DATA_SIZE, 8, pixel width in bits
ROW_SIZE, 28, pixels per row (image width)
COL_SIZE, 28, number of rows (image height)
KERNEL_SIZE, 3, window edge length used for win_inside; must satisfy 1 <= KERNEL_SIZE <= min(ROW_SIZE, COL_SIZE)

Ports:
clock  in  1  single clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
wr_en  in  1  RAM write strobe
wr_addr  in  $clog2(ROW_SIZE*COL_SIZE)  raster address (row*ROW_SIZE+col)
wr_data  in  DATA_SIZE  pixel to store
start  in  1  begin streaming; sampled only in IDLE
busy  out  1  streaming in progress
done  out  1  one-cycle pulse after last pixel
pixel_out  out  DATA_SIZE  streamed pixel
pixel_valid  out  1  pixel_out valid; connects to downstream data_in_valid
pixel_last  out  1  marks final pixel of image
win_inside  out  1  row>=KERNEL_SIZE-1 and col>=KERNEL_SIZE-1 for current pixel

Behaviour:
- Reset (async, reset_n=0) forces:
  - busy, done, pixel_valid, pixel_last and win_inside to 0.
  - pixel_out to 0.
  - state to IDLE, and row/col/address counters to 0.
  - RAM contents are not reset and are preserved across reset.
- RAM: ROW_SIZE*COL_SIZE x DATA_SIZE, one synchronous write port and one synchronous read port.
  - Writes are accepted only when busy=0.
  - wr_en while busy=1 is dropped.
  - An address >= ROW_SIZE*COL_SIZE is dropped.
- FSM states:
  - IDLE: start=1 -> STREAM. On that edge, busy rises, the read address is set to 0 and row/col are cleared.
  - STREAM: one read is issued per cycle, address incrementing by 1. Col wraps at ROW_SIZE-1 to 0 and row increments. After address ROW_SIZE*COL_SIZE-1 is issued -> DRAIN.
  - DRAIN: the final pixel is presented; then -> IDLE. done pulses for 1 cycle on entry to IDLE.
- Latency:
  - If the edge sampling start is edge E, pixel 0 is presented with pixel_valid=1 after edge E+2 (one RAM read, one output register).
- Contiguity:
  - pixel_valid stays high for exactly ROW_SIZE*COL_SIZE consecutive cycles with no gaps.
  - A gap would reset the downstream fill counter, so any gap is a bug.
- Output alignment:
  - pixel_last=1 only on the final pixel (row COL_SIZE-1, col ROW_SIZE-1).
  - win_inside is pipelined from the row/col counters so it aligns with its pixel_out.
  - busy falls on the same edge that clears pixel_valid after the final pixel.
  - done=1 in the cycle immediately after pixel_last.
- Start handling:
  - start while busy=1 is ignored and does not queue.
  - start in the same cycle as done is accepted. The next stream begins 2 edges later, with pixel_valid low for at least 1 cycle between images so the downstream buffer refills.
- Simultaneous events: wr_en together with start in IDLE performs the write; the read of address 0 on that edge sees the old data (read-before-write).
- Reset mid-stream: outputs drop asynchronously and the stream is abandoned with no done. A subsequent start replays from pixel 0.
- Single-pixel image (ROW_SIZE=COL_SIZE=1, KERNEL_SIZE=1): one valid cycle with pixel_last=1 and win_inside=1.

Test Plan:
1. ROW_SIZE=COL_SIZE=4, K=3: load addresses 0..15 with data 0x10..0x1F, pulse start at edge E -> pixel_valid high edges E+2..E+17, pixel_out 0x10..0x1F in order, pixel_last only with 0x1F, done at E+18, busy high E..E+17.
2. Same config, check win_inside -> high only for pixels at addresses 10,11,14,15 (row>=2, col>=2); 4 windows total.
3. Pulse start again at E+5 mid-stream and drive wr_en addr 3 data 0xAA at E+6 -> no restart; pixel 3 still 0x13; a later stream shows 0x13 at addr 3 (write dropped).
4. Assert reset_n=0 asynchronously while pixel 7 is presented -> pixel_valid/busy/pixel_out 0 immediately, no done; after release, start -> full 16-pixel replay of unchanged data.
5. start held high continuously -> back-to-back images, each exactly 16 contiguous valid cycles, ≥1 invalid cycle between images, done once per image.
6. Default 28x28, K=3, pixel = addr mod 256, connected to the window-buffer receiver -> 784 contiguous valid cycles, 676 win_inside pulses, first window has top-left pixel 0x00.
